ft_rx_cmd: RTL

FT_RX_CMD -- requirements
Module: ft_rx_cmd

---
 rtl/ft_rx_cmd_pkg.sv | 27 ++
 rtl/ft_rx_cmd.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/ft_rx_cmd_pkg.sv
// ft_rx_cmd_pkg
//   Shared FT2232H command-protocol definitions: packet length, byte
//   offsets within a packet, default sync nibble, and the receive FSM
//   state type. The transmitter side uses the same protocol constants.
package ft_rx_cmd_pkg;

   localparam int unsigned PKT_LEN = 4;

   // Byte offsets within a command packet
   localparam logic [1:0] IDX_ADDR = 2'd0;  // {sync, addr}
   localparam logic [1:0] IDX_DHI  = 2'd1;  // data[15:8]
   localparam logic [1:0] IDX_DLO  = 2'd2;  // data[7:0]
   localparam logic [1:0] IDX_CSUM = 2'(PKT_LEN - 1);  // b0^b1^b2

   localparam logic [3:0] SYNC_NIBBLE_DEF = 4'hA;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OE   = 2'd1,
      ST_READ = 2'd2
   } rx_state_t;

   function automatic logic sync_ok(input logic [7:0] b, input logic [3:0] sync);
      return b[7:4] == sync;
   endfunction

endpackage

// File: rtl/ft_rx_cmd.sv
// ft_rx_cmd
//   Reads 4-byte command packets from the FT2232H synchronous FIFO
//   (host -> FPGA direction) and decodes them into register writes.
//   Packet: {SYNC_NIBBLE, addr}, data[15:8], data[7:0], xor checksum.
//
// Ports
//   clk_i        60 MHz FT2232H CLKOUT, all logic on rising edge
//   rst_n        synchronous active-low reset
//   ft_rxf_n_i   low when the FT2232H holds data for us
//   ft_data_i    FIFO data bus (read side)
//   ft_oe_n_o    FT data-bus output enable, active low
//   ft_rd_n_o    FIFO read strobe, active low
//   tx_active_i  transmitter owns the bus; blocks starting a new read
//   rx_busy_o    high while ft_oe_n_o is low
//   cmd_valid_o  one-cycle pulse for a good command
//   cmd_addr_o   command register address (held until next good command)
//   cmd_data_o   command payload (held until next good command)
//   err_o        one-cycle pulse on framing, checksum or timeout error
module ft_rx_cmd
   import ft_rx_cmd_pkg::*;
#(
   parameter logic [3:0]  SYNC_NIBBLE    = SYNC_NIBBLE_DEF,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        clk_i,
   input  logic        rst_n,
   input  logic        ft_rxf_n_i,
   input  logic [7:0]  ft_data_i,
   output logic        ft_oe_n_o,
   output logic        ft_rd_n_o,
   input  logic        tx_active_i,
   output logic        rx_busy_o,
   output logic        cmd_valid_o,
   output logic [3:0]  cmd_addr_o,
   output logic [15:0] cmd_data_o,
   output logic        err_o
);

   localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   rx_state_t     state;
   logic [1:0]    idx;        // byte index, persists across bursts
   logic [7:0]    csum;       // running xor of bytes 0..2
   logic [3:0]    pkt_addr;
   logic [15:0]   pkt_data;
   logic [TW-1:0] tcnt;
   logic          byte_acc;

   // A byte transfers on any edge where the strobe is already low and
   // the FIFO still reports data.
   assign byte_acc = (state == ST_READ) && !ft_rd_n_o && !ft_rxf_n_i;

   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         ft_oe_n_o   <= 1'b1;
         ft_rd_n_o   <= 1'b1;
         rx_busy_o   <= 1'b0;
         cmd_valid_o <= 1'b0;
         err_o       <= 1'b0;
         cmd_addr_o  <= '0;
         cmd_data_o  <= '0;
         idx         <= '0;
         csum        <= '0;
         pkt_addr    <= '0;
         pkt_data    <= '0;
         tcnt        <= '0;
      end else begin
         cmd_valid_o <= 1'b0;
         err_o       <= 1'b0;

         // Bus handshake; tx_active_i only gates leaving IDLE
         case (state)
            ST_IDLE: begin
               if (!ft_rxf_n_i && !tx_active_i) begin
                  state     <= ST_OE;
                  ft_oe_n_o <= 1'b0;
                  rx_busy_o <= 1'b1;
               end
            end
            ST_OE: begin
               state     <= ST_READ;
               ft_rd_n_o <= 1'b0;
            end
            ST_READ: begin
               if (ft_rxf_n_i) begin
                  state     <= ST_IDLE;
                  ft_oe_n_o <= 1'b1;
                  ft_rd_n_o <= 1'b1;
                  rx_busy_o <= 1'b0;
               end
            end
            default: begin
               state     <= ST_IDLE;
               ft_oe_n_o <= 1'b1;
               ft_rd_n_o <= 1'b1;
               rx_busy_o <= 1'b0;
            end
         endcase

         // Packet assembly; an accepted byte takes priority over timeout
         if (byte_acc) begin
            tcnt <= '0;
            case (idx)
               IDX_ADDR: begin
                  if (sync_ok(ft_data_i, SYNC_NIBBLE)) begin
                     pkt_addr <= ft_data_i[3:0];
                     csum     <= ft_data_i;
                     idx      <= IDX_DHI;
                  end else begin
                     err_o <= 1'b1;
                  end
               end
               IDX_DHI: begin
                  pkt_data[15:8] <= ft_data_i;
                  csum           <= csum ^ ft_data_i;
                  idx            <= IDX_DLO;
               end
               IDX_DLO: begin
                  pkt_data[7:0] <= ft_data_i;
                  csum          <= csum ^ ft_data_i;
                  idx           <= IDX_CSUM;
               end
               default: begin
                  if (csum == ft_data_i) begin
                     cmd_valid_o <= 1'b1;
                     cmd_addr_o  <= pkt_addr;
                     cmd_data_o  <= pkt_data;
                  end else begin
                     err_o <= 1'b1;
                  end
                  idx <= IDX_ADDR;
               end
            endcase
         end else if (idx != IDX_ADDR) begin
            if (tcnt == TMO_LAST) begin
               err_o <= 1'b1;
               idx   <= IDX_ADDR;
               tcnt  <= '0;
            end else begin
               tcnt <= tcnt + 1'b1;
            end
         end else begin
            tcnt <= '0;
         end
      end
   end

endmodule
